// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan driver for a multi-digit seven-segment display.
// Feeds one nibble at a time to the decoder and drives the digit selects with an anti-ghosting blank gap.
module seven_seg_scan #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50_000,
   parameter int BLANK_CYC      = 500,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lz_en,
   output logic [3:0]            digit_code,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     sel,
   output logic                  frame_done
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0]     PRE_LAST   = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]     BLANK_LAST = PW'(BLANK_CYC - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic {BLANK, SHOW} state_t;

   state_t              state, state_nxt;
   logic [PW-1:0]       prescaler;
   logic [IW-1:0]       idx, idx_nxt;
   logic                slot_end, commit;
   logic                pending;
   logic [4*DIGITS-1:0] stage_nib, disp_nib;
   logic [DIGITS-1:0]   stage_dp, disp_dp;
   logic [DIGITS-1:0]   suppress;
   logic [DIGITS-1:0]   sel_nxt;
   logic [3:0]          code_nxt;
   logic                dp_nxt;

   assign slot_end = (prescaler == PRE_LAST);
   assign commit   = slot_end && (idx == IDX_LAST);

   // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prescaler <= '0;
         state     <= BLANK;
         idx       <= '0;
      end else begin
         prescaler <= slot_end ? '0 : prescaler + PW'(1);
         state     <= state_nxt;
         idx       <= idx_nxt;
      end
   end

   // NOTE: defaults first so no path through this block leaves a value unassigned (no latches).
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         BLANK: if (prescaler == BLANK_LAST) state_nxt = SHOW;
         SHOW: begin
            if (slot_end) begin
               state_nxt = BLANK;
               idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
         end
         default: state_nxt = BLANK;
      endcase
   end

   // Digit i>0 is blank when it and every digit above it are zero and its own dp is off.
   always_comb begin
      suppress = '0;
      for (int i = 1; i < DIGITS; i++) begin
         suppress[i] = ~disp_dp[i];
         for (int j = i; j < DIGITS; j++)
            if (disp_nib[4*j +: 4] != 4'h0) suppress[i] = 1'b0;
      end
   end

   always_comb begin
      sel_nxt  = SEL_OFF;
      code_nxt = disp_nib[{idx, 2'b00} +: 4];
      dp_nxt   = disp_dp[idx];
      if (state == SHOW && !(lz_en && suppress[idx]))
         sel_nxt[idx] = ~SEL_OFF[idx];
   end

   // A load on the commit edge bypasses staging so it shows in the frame that starts now.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stage_nib <= '0;
         stage_dp  <= '0;
         disp_nib  <= '0;
         disp_dp   <= '0;
         pending   <= 1'b0;
      end else begin
         if (load) begin
            stage_nib <= din;
            stage_dp  <= dp_in;
         end
         if (commit) begin
            if (load) begin
               disp_nib <= din;
               disp_dp  <= dp_in;
            end else if (pending) begin
               disp_nib <= stage_nib;
               disp_dp  <= stage_dp;
            end
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel        <= SEL_OFF;
         digit_code <= 4'h0;
         dp_out     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         sel        <= sel_nxt;
         digit_code <= code_nxt;
         dp_out     <= dp_nxt;
         frame_done <= commit;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed scenarios plus random loads,
// compared cycle by cycle against a frame/slot arithmetic model of the display.
module tb_seven_seg_scan;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = DIGITS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rstn, load, lz_en;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic [3:0]  digit_code;
   logic        dp_out;
   logic [3:0]  sel;
   logic        frame_done;

   always #5 clk = ~clk;

   seven_seg_scan #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .SEL_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rstn(rstn), .load(load), .din(din), .dp_in(dp_in), .lz_en(lz_en),
      .digit_code(digit_code), .dp_out(dp_out), .sel(sel), .frame_done(frame_done)
   );

   int checks   = 0;
   int failures = 0;

   // Model: edges since reset release, shown word, staged word.
   int          cyc;
   logic [15:0] m_nib, s_nib;
   logic [3:0]  m_dp, s_dp;
   bit          m_pend;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc = 0; m_nib = '0; s_nib = '0; m_dp = '0; s_dp = '0; m_pend = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel"},  {12'h0, sel}, 16'h000F);
      check({tag, "_code"}, {12'h0, digit_code}, 16'h0000);
      check({tag, "_dp"},   {15'h0, dp_out}, 16'h0000);
      check({tag, "_fd"},   {15'h0, frame_done}, 16'h0000);
   endtask

   // One clock: predict outputs from pre-edge state, clock, update model, compare.
   task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] p);
      int slot, dig;
      bit show, commit, supp;
      logic [3:0] e_sel, e_code;
      logic       e_dp;
      load = ld; din = d; dp_in = p;
      slot   = cyc % SCAN_DIV;
      dig    = (cyc / SCAN_DIV) % DIGITS;
      show   = slot >= BLANK_CYC;
      commit = (cyc % FRAME) == FRAME - 1;
      supp   = lz_en && dig > 0 && ((m_nib >> (4 * dig)) == 16'h0) && !m_dp[dig];
      e_sel  = (show && !supp) ? ~(4'b0001 << dig) : 4'hF;
      e_code = m_nib[4*dig +: 4];
      e_dp   = m_dp[dig];
      @(posedge clk); #1;
      if (commit) begin
         if (ld) begin
            m_nib = d; m_dp = p;
         end else if (m_pend) begin
            m_nib = s_nib; m_dp = s_dp;
         end
         m_pend = 1'b0;
      end else if (ld) begin
         m_pend = 1'b1;
      end
      if (ld) begin
         s_nib = d; s_dp = p;
      end
      cyc++;
      load = 1'b0;
      check("sel",        {12'h0, sel}, {12'h0, e_sel});
      check("digit_code", {12'h0, digit_code}, {12'h0, e_code});
      check("dp_out",     {15'h0, dp_out}, {15'h0, e_dp});
      check("frame_done", {15'h0, frame_done}, {15'h0, commit});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
   endtask

   // Advance until cyc sits at the given offset within a frame (at most one frame).
   task automatic run_to(input int target);
      for (int i = 0; i < FRAME && (cyc % FRAME) != target; i++) step(1'b0, 16'h0, 4'h0);
   endtask

   initial begin
      logic [15:0] rd;
      logic [3:0]  rp;
      bit          rl;

      rstn = 1'b1; load = 1'b0; lz_en = 1'b0; din = '0; dp_in = '0;
      model_reset();
      #3 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) rstn = 1'b1;
      #1 check_reset_outputs("post_release");

      // Idle scan of zeros: blank/show timing and frame_done cadence.
      run(2 * FRAME);

      // Mid-frame load only takes effect at the next frame.
      run_to(10);
      step(1'b1, 16'h1234, 4'b0010);
      run(2 * FRAME);

      // Two loads in one frame: the second wins.
      run_to(5);
      step(1'b1, 16'hAAAA, 4'b0000);
      run(7);
      step(1'b1, 16'h0507, 4'b0000);
      run(2 * FRAME);

      // Staged word pending, then a load exactly on the commit edge bypasses it.
      run_to(8);
      step(1'b1, 16'h3333, 4'b1111);
      run_to(FRAME - 1);
      step(1'b1, 16'h00C0, 4'b0000);
      run(2 * FRAME);

      // Leading-zero suppression, then a dp on the top digit defeats it.
      lz_en = 1'b1;
      run_to(3);
      step(1'b1, 16'h0040, 4'b0000);
      run(2 * FRAME);
      step(1'b1, 16'h0040, 4'b1000);
      run(2 * FRAME);

      // Random loads, words with random leading zeros, lz_en toggling.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) lz_en = ~lz_en;
         rl = ($urandom_range(0, 11) == 0);
         rd = 16'($urandom) >> $urandom_range(0, 15);
         rp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         step(rl, rd, rp);
      end

      // Asynchronous reset in the digit-2 show phase.
      lz_en = 1'b0;
      run_to(0);
      step(1'b1, 16'h9876, 4'b0101);
      run(2 * FRAME);
      run_to(20);
      #2 rstn = 1'b0;
      #1 check_reset_outputs("async_reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      model_reset();
      #1 check_reset_outputs("rerelease");
      run(FRAME + SCAN_DIV);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Multi-digit time-multiplexed scan driver for the seven-segment display path. It sits directly upstream of seven_seg_decoder.
- Latches a packed multi-digit nibble word from the counter/datapath side.
- Steps through the digits one at a time, presenting each digit's nibble on digit_code, which feeds the decoder din.
- Drives the digit-select (common anode/cathode) lines, with a blanking gap between digits to prevent ghosting.

Parameters:
DIGITS, 4, number of digits scanned (2..8).
SCAN_DIV, 50_000, clk cycles per digit slot (1 kHz per digit at 50 MHz).
BLANK_CYC, 500, cycles at the start of each slot with all selects inactive; must satisfy 1 <= BLANK_CYC < SCAN_DIV.
SEL_ACTIVE_LOW, 1, 1 = sel lines active-low, 0 = active-high.

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
load  input  1  one-cycle strobe; captures din/dp_in into the staging register
din  input  4*DIGITS  packed nibbles; din[3:0] = digit 0 (rightmost)
dp_in  input  DIGITS  decimal point per digit; bit i belongs to digit i
lz_en  input  1  leading-zero suppression enable
digit_code  output  4  nibble of the currently scanned digit, to the decoder din
dp_out  output  1  decimal point of the currently scanned digit, active-high
sel  output  DIGITS  digit select; polarity set by SEL_ACTIVE_LOW
frame_done  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0

Behaviour:
- Reset (async, rstn=0):
  - prescaler=0, idx=0, state=BLANK, pending=0.
  - staging and display registers = 0.
  - digit_code=0, dp_out=0, frame_done=0, sel all inactive (all 1s if SEL_ACTIVE_LOW=1).
  - Reset asserted mid-scan aborts immediately. The first slot after release is digit 0, starting in BLANK.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - slot_end when prescaler == SCAN_DIV-1.
- FSM:
  - BLANK: sel inactive. Go to SHOW when prescaler == BLANK_CYC-1.
  - SHOW: sel bit idx active. On slot_end go to BLANK and idx <= (idx == DIGITS-1) ? 0 : idx+1.
- Outputs:
  - All outputs are registered.
  - sel/digit_code/dp_out reflect the state/idx of the previous cycle (1-cycle latency).
  - digit_code and dp_out hold the value for idx through both BLANK and SHOW of that slot.
- Frame commit:
  - On the slot_end where idx == DIGITS-1: frame_done=1 for one cycle. If pending, display <= staging and pending <= 0.
- Load:
  - load=1: staging <= {din, dp_in}, pending <= 1.
  - Multiple loads within a frame: the last one wins.
  - load coinciding with a commit cycle: din/dp_in go straight to display and pending ends 0 (bypass).
  - The displayed word never changes mid-frame.
- Leading-zero suppression (lz_en=1):
  - Digit i (i>0) is suppressed when the display nibbles of digits DIGITS-1..i are all 0 and dp bit i is 0.
  - A suppressed digit keeps sel inactive for its whole slot. Timing and idx stepping are unchanged.
  - Digit 0 is never suppressed.
  - lz_en is sampled every cycle.
- Arithmetic: prescaler width = clog2(SCAN_DIV); idx width = clog2(DIGITS), minimum 1. No other arithmetic.

Test Plan:
1. DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, SEL_ACTIVE_LOW=1; release reset -> sel=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles with digit_code=0. Then digit 1 slot: sel=4'b1111 ×2, 4'b1101 ×6. frame_done pulses once every 32 cycles.
2. load with din=16'h1234, dp_in=4'b0010 mid-frame -> current frame keeps old data. Next frame: digit_code sequence 4,3,2,1 across slots; dp_out=1 only in the digit-1 slot.
3. Two loads in one frame (16'hAAAA then 16'h0507) -> next frame shows 7,0,5,0; 16'hAAAA is never displayed.
4. load of 16'h00C0 exactly on the commit cycle -> display updates the same frame (bypass); pending=0 afterwards; no extra commit at the next boundary.
5. lz_en=1, display 16'h0040, dp_in=0 -> digits 3 and 2 slots keep sel=4'b1111 all slot. Digits 1 (4) and 0 (0) are shown. Setting dp_in[3]=1 -> digit 3 is shown with digit_code=0.
6. Assert rstn=0 during the digit-2 SHOW phase -> sel goes inactive and outputs go to 0 asynchronously. After release, the scan restarts at digit 0 BLANK and the display register is 0.
